// File: rtl/ir_word_encoder.sv
// ir_word_encoder: packs instruction fields into IR words and streams them to memory via a small FIFO.
// Optional IR_ENC_RANGE_CHECK_EN rejects out-of-range constants and opcodes.
module ir_word_encoder #(
  parameter int AW = 9,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_last,
  input  logic [4:0]    opcode,
  input  logic [3:0]    ra,
  input  logic [3:0]    rb,
  input  logic [3:0]    rc,
  input  logic [31:0]   imm,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_data,
  output logic          mem_write,
  input  logic          mem_ack,
  output logic          busy,
  output logic          done,
  output logic [7:0]    err_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state;
  logic [31:0] fifo [DEPTH];
  logic [PW-1:0] rd, wr;
  logic [CW-1:0] count;
  logic take, push, pop, go, reject;
`ifdef IR_ENC_RANGE_CHECK_EN
  assign reject = (opcode > 5'd26) || !(&imm[31:14] || ~|imm[31:14]);
`else
  assign reject = 1'b0 & ^imm[31:15];
`endif
  assign in_ready = state == LOAD && count < CW'(DEPTH);
  assign take = in_valid && in_ready;
  assign push = take && !reject;
  assign mem_write = count != '0 && (state == LOAD || state == DRAIN);
  assign pop = mem_write && mem_ack;
  assign go = start && (state == IDLE || state == DONE);
  assign mem_data = count != '0 ? fifo[rd] : '0;
  assign busy = state == LOAD || state == DRAIN;
  assign done = state == DONE;
  always_ff @(posedge clock)
    if (push) fifo[wr] <= {opcode, ra, rb, rc, imm[14:0]};
  always_ff @(posedge clock) begin
    if (!clear) begin
      state <= IDLE;
      mem_addr <= '0;
      err_count <= '0;
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else if (go) begin
      state <= LOAD;
      mem_addr <= base_addr;
      err_count <= '0;
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (state == LOAD && take && in_last) state <= DRAIN;
      // the final ack and the DONE transition share an edge
      if (state == DRAIN && count == CW'(pop)) state <= DONE;
      if (push) wr <= wr + 1'b1;
      if (pop) begin
        rd <= rd + 1'b1;
        mem_addr <= mem_addr + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
      if (take && reject && err_count != 8'hFF) err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_ir_word_encoder.sv
// tb_ir_word_encoder: directed checks of packing, backpressure, wrap, range handling and reset.
module tb_ir_word_encoder;
  logic clock = 0, clear = 0, start = 0, in_valid = 0, in_last = 0, mem_ack = 0;
  logic [8:0] base_addr = '0;
  logic [4:0] opcode = '0;
  logic [3:0] ra = '0, rb = '0, rc = '0;
  logic [31:0] imm = '0;
  logic in_ready, mem_write, busy, done;
  logic [8:0] mem_addr;
  logic [31:0] mem_data;
  logic [7:0] err_count;
  int checks = 0, errors = 0;
  logic [8:0] qa[$];
  logic [31:0] qd[$];

  ir_word_encoder #(.AW(9), .DEPTH(4)) dut (
    .clock(clock), .clear(clear), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .opcode(opcode), .ra(ra), .rb(rb), .rc(rc), .imm(imm),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_write(mem_write),
    .mem_ack(mem_ack), .busy(busy), .done(done), .err_count(err_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock)
    if (clear && mem_write && mem_ack) begin
      qa.push_back(mem_addr);
      qd.push_back(mem_data);
    end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  function automatic logic [31:0] pw(int i);
    logic [4:0] o = 5'(i + 1);
    logic [3:0] a = 4'(i), b = 4'(i + 2), c = 4'(i + 3);
    logic [14:0] k = 15'(i * 100);
    return {o, a, b, c, k};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic begin_session(input logic [8:0] base);
    qa.delete();
    qd.delete();
    base_addr = base;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic set_fields(input int i, input logic last);
    opcode = 5'(i + 1);
    ra = 4'(i);
    rb = 4'(i + 2);
    rc = 4'(i + 3);
    imm = i * 100;
    in_last = last;
    in_valid = 1;
  endtask

  task automatic wait_done(input string name);
    for (int k = 0; k < 30 && !done; k++) tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL %s_done: got %b want 1", name, done); end
  endtask

  task automatic test_reset();
    clear = 0;
    tick();
    tick();
    checks += 7;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mem_write: got %b want 0", mem_write); end
    if (mem_addr !== 9'h0) begin errors++; $display("FAIL rst_mem_addr: got %h want 000", mem_addr); end
    if (mem_data !== 32'h0) begin errors++; $display("FAIL rst_mem_data: got %h want 0", mem_data); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    if (err_count !== 8'h0) begin errors++; $display("FAIL rst_err_count: got %0d want 0", err_count); end
    clear = 1;
    tick();
  endtask

  task automatic test_basic_pack();
    mem_ack = 1;
    begin_session(9'h010);
    checks += 2;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b want 1", busy); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
    opcode = 3; ra = 2; rb = 3; rc = 4; imm = 5; in_last = 1; in_valid = 1;
    tick();
    in_valid = 0;
    in_last = 0;
    checks += 3;
    if (mem_write !== 1'b1) begin errors++; $display("FAIL basic_write: got %b want 1", mem_write); end
    if (mem_data !== 32'h191A0005) begin errors++; $display("FAIL basic_data: got %h want 191a0005", mem_data); end
    if (mem_addr !== 9'h010) begin errors++; $display("FAIL basic_addr: got %h want 010", mem_addr); end
    tick();
    checks += 4;
    if (done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", done); end
    if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    if (mem_write !== 1'b0) begin errors++; $display("FAIL basic_write_end: got %b want 0", mem_write); end
    if (qa.size() != 1 || qd[0] !== 32'h191A0005 || qa[0] !== 9'h010)
      begin errors++; $display("FAIL basic_log: got %0d writes want 1 of 191a0005@010", qa.size()); end
  endtask

  task automatic test_negative_imm();
    mem_ack = 0;
    begin_session(9'h020);
    opcode = 0; ra = 0; rb = 0; rc = 0; imm = 32'hFFFF_FFFF; in_last = 1; in_valid = 1;
    tick();
    in_valid = 0;
    in_last = 0;
    checks++;
    if (mem_data !== 32'h00007FFF) begin errors++; $display("FAIL neg_data: got %h want 00007fff", mem_data); end
    tick();
    checks += 2;
    if (mem_data !== 32'h00007FFF) begin errors++; $display("FAIL neg_hold_data: got %h want 00007fff", mem_data); end
    if (mem_addr !== 9'h020) begin errors++; $display("FAIL neg_hold_addr: got %h want 020", mem_addr); end
    mem_ack = 1;
    tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL neg_done: got %b want 1", done); end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    logic took;
    mem_ack = 0;
    begin_session(9'h040);
    for (int c = 0; c < 6; c++) begin
      set_fields(acc, acc == 5);
      took = in_ready;
      tick();
      if (took) acc++;
    end
    checks += 4;
    if (acc != 4) begin errors++; $display("FAIL bp_accepts: got %0d want 4", acc); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    if (mem_data !== pw(0)) begin errors++; $display("FAIL bp_hold_data: got %h want %h", mem_data, pw(0)); end
    if (mem_addr !== 9'h040) begin errors++; $display("FAIL bp_hold_addr: got %h want 040", mem_addr); end
    mem_ack = 1;
    for (int c = 0; c < 30 && acc < 6; c++) begin
      set_fields(acc, acc == 5);
      took = in_ready;
      tick();
      if (took) acc++;
    end
    in_valid = 0;
    in_last = 0;
    wait_done("bp");
    checks++;
    if (qa.size() != 6) begin errors++; $display("FAIL bp_count: got %0d want 6", qa.size()); end
    for (int i = 0; i < qa.size() && i < 6; i++) begin
      checks++;
      if (qa[i] !== 9'(9'h040 + i) || qd[i] !== pw(i))
        begin errors++; $display("FAIL bp_word%0d: got %h@%h want %h@%h", i, qd[i], qa[i], pw(i), 9'(9'h040 + i)); end
    end
  endtask

  task automatic test_back_to_back();
    mem_ack = 1;
    begin_session(9'h100);
    for (int i = 0; i < 4; i++) begin
      set_fields(i, i == 3);
      tick();
    end
    in_valid = 0;
    in_last = 0;
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL b2b_early_done: got %b want 0", done); end
    tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", done); end
    checks++;
    if (qa.size() != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", qa.size()); end
    for (int i = 0; i < qa.size() && i < 4; i++) begin
      checks++;
      if (qa[i] !== 9'(9'h100 + i) || qd[i] !== pw(i))
        begin errors++; $display("FAIL b2b_word%0d: got %h@%h want %h", i, qd[i], qa[i], pw(i)); end
    end
  endtask

  task automatic test_wrap();
    mem_ack = 1;
    begin_session(9'h1FF);
    for (int i = 0; i < 2; i++) begin
      set_fields(i, i == 1);
      tick();
    end
    in_valid = 0;
    in_last = 0;
    wait_done("wrap");
    checks++;
    if (qa.size() != 2 || qa[0] !== 9'h1FF || qa[1] !== 9'h000)
      begin errors++; $display("FAIL wrap_addr: got %0d writes want 1ff then 000", qa.size()); end
  endtask

  task automatic test_range();
    mem_ack = 1;
    begin_session(9'h030);
    opcode = 0; ra = 0; rb = 0; rc = 0; imm = 16384; in_last = 1; in_valid = 1;
    tick();
    in_valid = 0;
    in_last = 0;
`ifdef IR_ENC_RANGE_CHECK_EN
    checks += 2;
    if (mem_write !== 1'b0) begin errors++; $display("FAIL range_write: got %b want 0", mem_write); end
    if (err_count !== 8'd1) begin errors++; $display("FAIL range_err: got %0d want 1", err_count); end
    tick();
    checks += 2;
    if (done !== 1'b1) begin errors++; $display("FAIL range_done: got %b want 1", done); end
    if (qa.size() != 0) begin errors++; $display("FAIL range_log: got %0d writes want 0", qa.size()); end
`else
    checks += 2;
    if (mem_data !== 32'h00004000) begin errors++; $display("FAIL range_data: got %h want 00004000", mem_data); end
    if (err_count !== 8'd0) begin errors++; $display("FAIL range_err: got %0d want 0", err_count); end
    tick();
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL range_done: got %b want 1", done); end
`endif
  endtask

  task automatic test_reset_mid();
    mem_ack = 0;
    begin_session(9'h080);
    for (int i = 0; i < 3; i++) begin
      set_fields(i, 1'b0);
      tick();
    end
    in_valid = 0;
    checks++;
    if (mem_write !== 1'b1) begin errors++; $display("FAIL mid_pre_write: got %b want 1", mem_write); end
    clear = 0;
    tick();
    checks += 4;
    if (mem_write !== 1'b0) begin errors++; $display("FAIL mid_write: got %b want 0", mem_write); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
    if (mem_addr !== 9'h0) begin errors++; $display("FAIL mid_addr: got %h want 000", mem_addr); end
    clear = 1;
    mem_ack = 1;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (qa.size() != 0 || mem_write !== 1'b0)
      begin errors++; $display("FAIL mid_no_writes: got %0d writes want 0", qa.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_pack();
    test_negative_imm();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_range();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
